// File: rtl/mem_lsu_if.sv
`timescale 1ns/1ps
// Data-bus bundle between the MEM-stage load/store unit and the memory
// system: a registered request side and a one-cycle acknowledge side.
interface mem_lsu_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_sel;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ack;

   // The load/store unit issues requests and consumes the acknowledge.
   modport master (
      output bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
      input  bus_rdata, bus_ack
   );

   // The memory side answers requests.
   modport slave (
      input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
      output bus_rdata, bus_ack
   );
endinterface

// File: rtl/mem_lsu.sv
`timescale 1ns/1ps
// mem_lsu: MEM stage of the 5-stage RISC-V pipeline.
// Non-memory instructions flow straight through to mem_wb. Loads and stores
// run one request/acknowledge transaction on the data bus while holding
// stallreq, with byte-lane steering, load extension, misalignment and
// illegal-funct3 detection, and an optional acknowledge timeout.
module mem_lsu #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_hold,
   input  logic [4:0]  ex_wd,
   input  logic        ex_wreg,
   input  logic [31:0] ex_wdata,
   input  logic        ex_mem_re,
   input  logic        ex_mem_we,
   input  logic [2:0]  ex_funct3,
   input  logic [31:0] ex_mem_addr,
   input  logic [31:0] ex_mem_sdata,
   output logic [4:0]  mem_wd,
   output logic        mem_wreg,
   output logic [31:0] mem_wdata,
   output logic        stallreq,
   output logic        mem_err,
   mem_lsu_if.master   bus
);

   // Counter wide enough to hold TIMEOUT; at least one bit when disabled.
   localparam int unsigned       CNT_W    = $clog2(TIMEOUT + 2);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   // Last BUSY cycle (counter value) in which an acknowledge is still accepted.
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? CNT_W'(0) : CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------

   // funct3 encodings the stage understands for the given direction.
   function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
      logic ok;
      if (is_store) begin
         ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
      end else begin
         ok = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
      end
      return ok;
   endfunction

   // Natural alignment check; size is funct3[1:0] (byte/half/word).
   function automatic logic addr_aligned(input logic [1:0] size, input logic [1:0] off);
      logic ok;
      case (size)
         2'b00:   ok = 1'b1;
         2'b01:   ok = ~off[0];
         2'b10:   ok = (off == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Byte enables for an access of the given size at the given byte offset.
   function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] sel;
      case (size)
         2'b00:   sel = 4'b0001 << off;
         2'b01:   sel = off[1] ? 4'b1100 : 4'b0011;
         2'b10:   sel = 4'b1111;
         default: sel = 4'b0000;
      endcase
      return sel;
   endfunction

   // Store data replicated across every lane so the enables pick the right one.
   function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] sdata);
      logic [31:0] wd;
      case (size)
         2'b00:   wd = {4{sdata[7:0]}};
         2'b01:   wd = {2{sdata[15:0]}};
         default: wd = sdata;
      endcase
      return wd;
   endfunction

   // Pull the addressed byte/half out of the bus word and extend it.
   function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] rdata);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      case (off)
         2'b00:   b = rdata[7:0];
         2'b01:   b = rdata[15:8];
         2'b10:   b = rdata[23:16];
         default: b = rdata[31:24];
      endcase
      h = off[1] ? rdata[31:16] : rdata[15:0];
      case (f3)
         3'b000:  res = {{24{b[7]}}, b};
         3'b100:  res = {24'h00_0000, b};
         3'b001:  res = {{16{h[15]}}, h};
         3'b101:  res = {16'h0000, h};
         3'b010:  res = rdata;
         default: res = 32'h0000_0000;
      endcase
      return res;
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      rdata_q, rdata_d;
   logic [2:0]       f3_q, f3_d;
   logic [1:0]       off_q, off_d;
   logic             load_q, load_d;
   logic             tmo_q, tmo_d;
   logic             err_q, err_d;
   logic             req_q, req_d;
   logic             we_q, we_d;
   logic [31:0]      addr_q, addr_d;
   logic [3:0]       sel_q, sel_d;
   logic [31:0]      bwd_q, bwd_d;

   logic             is_mem_s;
   logic             op_ok_s;

   // Decode of the instruction currently presented by ex_mem.
   always_comb begin
      is_mem_s = ex_mem_re | ex_mem_we;
      op_ok_s  = f3_legal(ex_mem_we, ex_funct3) &&
                 addr_aligned(ex_funct3[1:0], ex_mem_addr[1:0]);
   end

   // State, bus and result registers; reset abandons any access in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= CNT_W'(0);
         rdata_q <= 32'h0000_0000;
         f3_q    <= 3'b000;
         off_q   <= 2'b00;
         load_q  <= 1'b0;
         tmo_q   <= 1'b0;
         err_q   <= 1'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= 32'h0000_0000;
         sel_q   <= 4'b0000;
         bwd_q   <= 32'h0000_0000;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
         load_q  <= load_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         sel_q   <= sel_d;
         bwd_q   <= bwd_d;
      end
   end

   // Next-state logic and the writeback/stall outputs of the stage.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rdata_d   = rdata_q;
      f3_d      = f3_q;
      off_d     = off_q;
      load_d    = load_q;
      tmo_d     = tmo_q;
      err_d     = 1'b0;
      req_d     = req_q;
      we_d      = we_q;
      addr_d    = addr_q;
      sel_d     = sel_q;
      bwd_d     = bwd_q;
      mem_wd    = ex_wd;
      mem_wreg  = ex_wreg;
      mem_wdata = ex_wdata;
      stallreq  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (is_mem_s) begin
               mem_wreg = 1'b0;
               if (op_ok_s) begin
                  // Launch the single bus access for this instruction.
                  stallreq = 1'b1;
                  state_d  = S_BUSY;
                  cnt_d    = CNT_W'(0);
                  req_d    = 1'b1;
                  we_d     = ex_mem_we;
                  addr_d   = {ex_mem_addr[31:2], 2'b00};
                  sel_d    = lane_sel(ex_funct3[1:0], ex_mem_addr[1:0]);
                  bwd_d    = lane_wdata(ex_funct3[1:0], ex_mem_sdata);
                  f3_d     = ex_funct3;
                  off_d    = ex_mem_addr[1:0];
                  load_d   = ~ex_mem_we;
                  tmo_d    = 1'b0;
               end else begin
                  // Rejected without touching the bus; the pipeline moves on.
                  err_d = 1'b1;
               end
            end else begin
               state_d = S_IDLE;
            end
         end

         S_BUSY: begin
            mem_wreg = 1'b0;
            stallreq = 1'b1;
            // An acknowledge in the final allowed cycle still wins over the timeout.
            if (bus.bus_ack) begin
               req_d   = 1'b0;
               rdata_d = bus.bus_rdata;
               state_d = S_DONE;
            end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
               req_d   = 1'b0;
               err_d   = 1'b1;
               tmo_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         S_DONE: begin
            mem_wreg  = ex_wreg & load_q & ~tmo_q;
            mem_wdata = load_extract(f3_q, off_q, rdata_q);
            // Stay put while mem_wb is frozen so the result is not lost.
            if (stall_hold) begin
               state_d = S_DONE;
            end else begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d  = S_IDLE;
            req_d    = 1'b0;
            mem_wreg = 1'b0;
         end
      endcase

      if (rst) begin
         mem_wd    = 5'd0;
         mem_wreg  = 1'b0;
         mem_wdata = 32'h0000_0000;
         stallreq  = 1'b0;
      end else begin
         stallreq = stallreq;
      end
   end

   assign mem_err       = err_q;
   assign bus.bus_req   = req_q;
   assign bus.bus_we    = we_q;
   assign bus.bus_addr  = addr_q;
   assign bus.bus_sel   = sel_q;
   assign bus.bus_wdata = bwd_q;

endmodule

// File: tb/tb_mem_lsu.sv
`timescale 1ns/1ps
// tb_mem_lsu: randomized instruction stream against a transaction-level
// model of the MEM stage, plus directed cases with literal expectations.
module tb_mem_lsu;
   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_hold;
   logic [4:0]  ex_wd;
   logic        ex_wreg;
   logic [31:0] ex_wdata;
   logic        ex_mem_re;
   logic        ex_mem_we;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_mem_addr;
   logic [31:0] ex_mem_sdata;
   logic [4:0]  mem_wd;
   logic        mem_wreg;
   logic [31:0] mem_wdata;
   logic        stallreq;
   logic        mem_err;

   mem_lsu_if bus_if ();

   mem_lsu #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .stall_hold(stall_hold),
      .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
      .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we), .ex_funct3(ex_funct3),
      .ex_mem_addr(ex_mem_addr), .ex_mem_sdata(ex_mem_sdata),
      .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
      .stallreq(stallreq), .mem_err(mem_err), .bus(bus_if)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Per-cycle expectations produced by the stimulus/model process.
   bit          chk_en = 1'b0;
   bit          e_stall, e_wreg, e_err, e_req, e_data_chk, e_bus_chk, e_we;
   logic [4:0]  e_wd;
   logic [31:0] e_wdata, e_addr, e_bwd;
   logic [3:0]  e_sel;
   bit          pend_err = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model of the stage rules ----------------
   function automatic bit legal(input bit st, input logic [2:0] f3, input logic [1:0] off);
      int  sz = int'(f3) % 4;
      bit  f3ok = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      bit  al = (sz == 0) || (sz == 1 && off % 2 == 0) || (sz == 2 && off == 2'd0);
      return f3ok && al;
   endfunction

   function automatic logic [3:0] model_sel(input logic [2:0] f3, input logic [1:0] off);
      int sz = int'(f3) % 4;
      if (sz == 0) return 4'(1 << off);
      if (sz == 1) return (off >= 2'd2) ? 4'd12 : 4'd3;
      return 4'd15;
   endfunction

   function automatic logic [31:0] model_bwd(input logic [2:0] f3, input logic [31:0] sd);
      int sz = int'(f3) % 4;
      if (sz == 0) return (sd & 32'hFF) * 32'h0101_0101;
      if (sz == 1) return (sd & 32'hFFFF) * 32'h0001_0001;
      return sd;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] rd);
      logic [31:0] v;
      int sz = int'(f3) % 4;
      if (sz == 0) begin
         v = (rd >> (8 * off)) & 32'hFF;
         if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
      end else if (sz == 1) begin
         v = (rd >> (16 * (off / 2))) & 32'hFFFF;
         if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
      end else begin
         v = rd;
      end
      return v;
   endfunction

   // Cycle compare of DUT outputs against the model's expectations.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("stallreq", 32'(stallreq), 32'(e_stall));
         chk("mem_wreg", 32'(mem_wreg), 32'(e_wreg));
         chk("mem_err", 32'(mem_err), 32'(e_err));
         chk("bus_req", 32'(bus_if.bus_req), 32'(e_req));
         if (e_data_chk) begin
            chk("mem_wd", 32'(mem_wd), 32'(e_wd));
            chk("mem_wdata", mem_wdata, e_wdata);
         end
         if (e_bus_chk) begin
            chk("bus_we", 32'(bus_if.bus_we), 32'(e_we));
            chk("bus_addr", bus_if.bus_addr, e_addr);
            chk("bus_sel", 32'(bus_if.bus_sel), 32'(e_sel));
            if (e_we) chk("bus_wdata", bus_if.bus_wdata, e_bwd);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic spur_ack();
      bus_if.bus_ack   = ($urandom_range(0, 3) == 0);
      bus_if.bus_rdata = $urandom();
   endtask

   // Present one instruction and step it through the stage. d = ack delay in
   // bus cycles (>= TMO means no ack), h = DONE cycles held by stall_hold.
   task automatic run_instr(
      input logic re, input logic we, input logic [2:0] f3, input logic [31:0] addr,
      input logic [31:0] sdata, input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
      input int d, input int h, input logic [31:0] rd,
      input bit lit_en, input logic [31:0] lit_addr, input logic [3:0] lit_sel,
      input logic [31:0] lit_bwd, input logic [31:0] lit_res,
      output int nstall, output int nreq);
      bit is_mem, ok, acked;
      int nb;
      is_mem = re | we;
      ok     = is_mem && legal(we, f3, addr[1:0]);
      acked  = (d < TMO);
      nstall = 0;
      nreq   = 0;
      ex_mem_re = re; ex_mem_we = we; ex_funct3 = f3; ex_mem_addr = addr;
      ex_mem_sdata = sdata; ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata;
      stall_hold = 1'($urandom_range(0, 1));
      spur_ack();
      // IDLE cycle
      e_err = pend_err; pend_err = is_mem && !ok;
      e_req = 1'b0; e_bus_chk = 1'b0;
      e_stall = ok; e_wreg = is_mem ? 1'b0 : wreg;
      e_data_chk = !is_mem; e_wd = wd; e_wdata = wdata;
      @(negedge clk);
      nstall += int'(stallreq); nreq += int'(bus_if.bus_req);
      if (lit_en && !is_mem) chk("lit_alu_wdata", mem_wdata, lit_res);
      tick();
      if (ok) begin
         nb = acked ? d + 1 : TMO;
         for (int b = 0; b < nb; b++) begin
            e_err = pend_err; pend_err = !acked && (b == nb - 1);
            e_stall = 1'b1; e_wreg = 1'b0; e_data_chk = 1'b0;
            e_req = 1'b1; e_bus_chk = 1'b1; e_we = we;
            e_addr = addr & 32'hFFFF_FFFC; e_sel = model_sel(f3, addr[1:0]);
            e_bwd = model_bwd(f3, sdata);
            stall_hold = 1'($urandom_range(0, 1));
            bus_if.bus_ack   = (b == d);
            bus_if.bus_rdata = (b == d) ? rd : $urandom();
            @(negedge clk);
            nstall += int'(stallreq); nreq += int'(bus_if.bus_req);
            if (lit_en && b == 0) begin
               chk("lit_bus_addr", bus_if.bus_addr, lit_addr);
               chk("lit_bus_sel", 32'(bus_if.bus_sel), 32'(lit_sel));
               if (we) chk("lit_bus_wdata", bus_if.bus_wdata, lit_bwd);
            end
            tick();
         end
         for (int k = 0; k <= h; k++) begin
            e_err = pend_err; pend_err = 1'b0;
            e_stall = 1'b0; e_req = 1'b0; e_bus_chk = 1'b0;
            e_wreg = !we && wreg && acked;
            e_data_chk = !we && acked; e_wd = wd;
            e_wdata = model_load(f3, addr[1:0], rd);
            stall_hold = (k < h);
            spur_ack();
            @(negedge clk);
            nstall += int'(stallreq); nreq += int'(bus_if.bus_req);
            if (lit_en && !we && acked && k == h) chk("lit_load_wdata", mem_wdata, lit_res);
            tick();
         end
      end
   endtask

   initial begin
      int ns, nr, d, h;
      logic re, we;
      logic [2:0] f3;
      logic [31:0] a;
      rst = 1'b1;
      stall_hold = 1'b0;
      ex_wd = 5'd5; ex_wreg = 1'b1; ex_wdata = 32'h1234; ex_mem_re = 1'b0; ex_mem_we = 1'b0;
      ex_funct3 = 3'd0; ex_mem_addr = 32'h0; ex_mem_sdata = 32'h0;
      bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
      tick(); tick();
      // Reset state: everything zero even with inputs presented.
      chk("rst_mem_wd", 32'(mem_wd), 32'd0);
      chk("rst_mem_wreg", 32'(mem_wreg), 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_stallreq", 32'(stallreq), 32'd0);
      chk("rst_mem_err", 32'(mem_err), 32'd0);
      chk("rst_bus_req", 32'(bus_if.bus_req), 32'd0);
      chk("rst_bus_sel", 32'(bus_if.bus_sel), 32'd0);
      rst = 1'b0;
      chk_en = 1'b1;

      // Directed cases with hand-computed results.
      run_instr(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234, 0, 0, 32'h0,
                1'b1, 32'h0, 4'h0, 32'h0, 32'h1234, ns, nr);
      chk("lit_alu_nreq", 32'(nr), 32'd0);
      run_instr(1'b1, 1'b0, 3'b000, 32'h1003, 32'h0, 5'd7, 1'b1, 32'h0, 1, 0, 32'h80FF_FF7F,
                1'b1, 32'h1000, 4'b1000, 32'h0, 32'hFFFF_FF80, ns, nr);
      chk("lit_lb_nstall", 32'(ns), 32'd3);
      run_instr(1'b1, 1'b0, 3'b100, 32'h1003, 32'h0, 5'd7, 1'b1, 32'h0, 1, 0, 32'h80FF_FF7F,
                1'b1, 32'h1000, 4'b1000, 32'h0, 32'h0000_0080, ns, nr);
      run_instr(1'b0, 1'b1, 3'b001, 32'h2002, 32'hDEAD_BEEF, 5'd3, 1'b1, 32'h0, 0, 0, 32'h0,
                1'b1, 32'h2000, 4'b1100, 32'hBEEF_BEEF, 32'h0, ns, nr);
      run_instr(1'b1, 1'b0, 3'b010, 32'h0002, 32'h0, 5'd9, 1'b1, 32'h0, 0, 0, 32'h0,
                1'b0, 32'h0, 4'h0, 32'h0, 32'h0, ns, nr);
      chk("lit_mis_nreq", 32'(nr), 32'd0);
      chk("lit_mis_nstall", 32'(ns), 32'd0);
      run_instr(1'b1, 1'b0, 3'b010, 32'h0100, 32'h0, 5'd9, 1'b1, 32'h0, TMO, 0, 32'h0,
                1'b0, 32'h0, 4'h0, 32'h0, 32'h0, ns, nr);
      chk("lit_tmo_nreq", 32'(nr), 32'(TMO));
      run_instr(1'b1, 1'b0, 3'b010, 32'h0104, 32'h0, 5'd10, 1'b1, 32'h0, TMO - 1, 3, 32'hCAFE_F00D,
                1'b1, 32'h0104, 4'b1111, 32'h0, 32'hCAFE_F00D, ns, nr);
      chk("lit_lastack_nreq", 32'(nr), 32'(TMO));

      // Reset while a load is on the bus.
      chk_en = 1'b0;
      ex_mem_re = 1'b1; ex_mem_we = 1'b0; ex_funct3 = 3'b010; ex_mem_addr = 32'h0200;
      bus_if.bus_ack = 1'b0;
      tick();
      chk("busy_bus_req", 32'(bus_if.bus_req), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_bus_req", 32'(bus_if.bus_req), 32'd0);
      chk("async_rst_stallreq", 32'(stallreq), 32'd0);
      chk("async_rst_mem_wdata", mem_wdata, 32'd0);
      tick();
      rst = 1'b0;
      pend_err = 1'b0;
      chk_en = 1'b1;
      run_instr(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd17, 1'b1, 32'hA5A5_0001, 0, 0, 32'h0,
                1'b1, 32'h0, 4'h0, 32'h0, 32'hA5A5_0001, ns, nr);

      // Randomized instruction stream.
      for (int i = 0; i < 300; i++) begin
         int kind = $urandom_range(0, 9);
         re = (kind >= 3 && kind < 7);
         we = (kind >= 7);
         f3 = we ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
         a = $urandom();
         if ($urandom_range(0, 3) != 0) begin
            if (f3[1:0] == 2'b01) a[0] = 1'b0;
            if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
         end
         d = $urandom_range(0, TMO + 1);
         h = $urandom_range(0, 2);
         run_instr(re, we, f3, a, $urandom(), 5'($urandom()), 1'($urandom()), $urandom(),
                   d, h, $urandom(), 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, ns, nr);
      end

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
MEM stage of the 5-stage RISC-V pipeline, sitting between ex_mem and mem_wb and driving mem_wb's mem_wd/mem_wreg/mem_wdata inputs. Non-memory instructions pass straight through. Loads and stores run a multi-cycle request/acknowledge transaction on the data bus, holding stallreq high to ctrl until the access completes. The stage does byte-lane steering, load sign/zero extension, misalignment checking and a bus timeout.

Parameters:
TIMEOUT, 255, max cycles to wait for bus_ack before aborting; 0 disables the timeout (waits forever)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
stall_hold  input  1  stall[4] from ctrl; while high, a completed access stays presented
ex_wd  input  5  destination register from ex_mem
ex_wreg  input  1  register write enable from ex_mem
ex_wdata  input  32  ALU result (non-memory instructions)
ex_mem_re  input  1  instruction is a load
ex_mem_we  input  1  instruction is a store
ex_funct3  input  3  RISC-V funct3 of load/store
ex_mem_addr  input  32  effective address
ex_mem_sdata  input  32  store data (rs2)
mem_wd  output  5  to mem_wb
mem_wreg  output  1  to mem_wb
mem_wdata  output  32  to mem_wb
stallreq  output  1  stall request to ctrl
mem_err  output  1  one-cycle pulse: misaligned, illegal funct3 or timeout
bus_req  output  1  bus request, registered
bus_we  output  1  bus write, registered
bus_addr  output  32  word-aligned address {addr[31:2],2'b00}, registered
bus_sel  output  4  byte enables, registered
bus_wdata  output  32  lane-steered store data, registered
bus_rdata  input  32  read data, valid with bus_ack
bus_ack  input  1  one-cycle acknowledge

Behaviour:
- Reset (async): state=IDLE, timeout counter=0, rdata buffer=0, all bus_* outputs=0, mem_err=0. While rst is high, mem_wd=0, mem_wreg=0, mem_wdata=0, stallreq=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE, no memory op (re=we=0): combinational pass-through. mem_wd=ex_wd, mem_wreg=ex_wreg, mem_wdata=ex_wdata, stallreq=0.
- IDLE, memory op, invalid funct3 (load: 011/110/111; store: anything other than 000/001/010): no bus access, mem_wreg=0, mem_err=1, stallreq=0, stay in IDLE.
- IDLE, memory op, misaligned (H/HU with addr[0]=1; W with addr[1:0]!=0): same as invalid funct3.
- IDLE, valid memory op: stallreq=1 combinationally and mem_wreg=0. On the next edge, register bus_req=1, bus_we=ex_mem_we, bus_addr, bus_sel and bus_wdata, then go to BUSY.
- Byte enables: SB sel = 4'b0001<<addr[1:0], wdata = byte replicated ×4. SH sel = addr[1] ? 1100 : 0011, wdata = half replicated ×2. SW sel = 1111. Loads use the same sel as the same-size store.
- BUSY: stallreq=1, mem_wreg=0, counter increments every cycle.
  - On bus_ack: bus_req←0, rdata buffer←bus_rdata, go to DONE.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT with no ack: bus_req←0, mem_err pulses 1 for one cycle, go to DONE with mem_wreg forced to 0 for that instruction.
  - An ack in the same cycle the counter reaches TIMEOUT counts as success.
- DONE: stallreq=0, mem_wd=ex_wd, mem_wreg=ex_wreg for loads (0 for stores or after a timeout).
  - mem_wdata is the extracted load data. LB/LBU take the byte at addr[1:0]; LH/LHU take the half at addr[1]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word.
  - Leave to IDLE on the next edge unless stall_hold=1, in which case stay in DONE holding the outputs.
- One bus transaction per instruction. IDLE is only re-entered after mem_wb has sampled the result, so an instruction is never re-issued.
- bus_ack seen in IDLE or DONE is ignored.
- Reset mid-transaction: bus_req drops immediately and the access is abandoned.

Test Plan:
- ADD pass-through: ex_wd=5, ex_wreg=1, ex_wdata=0x1234, no mem op -> same cycle mem_wd=5, mem_wreg=1, mem_wdata=0x1234, stallreq=0, bus_req stays 0.
- LB sign-extend: addr=0x1003, bus_rdata=0x80FF_FF7F, ack 2 cycles after bus_req -> bus_addr=0x1000, bus_sel=1000, stallreq high 3 cycles, then mem_wdata=0xFFFF_FF80, mem_wreg=1. LBU at the same address gives 0x0000_0080.
- SH: addr=0x2002, sdata=0xDEAD_BEEF -> bus_we=1, bus_sel=1100, bus_wdata=0xBEEF_BEEF, mem_wreg=0 in DONE.
- Misaligned LW: addr=0x0002 -> mem_err pulses once, bus_req never asserts, stallreq=0, mem_wreg=0.
- Timeout: TIMEOUT=4, no ack -> bus_req drops after 4 BUSY cycles, one mem_err pulse, mem_wreg=0, stallreq releases.
- Hold and reset: stall_hold=1 in DONE for 3 cycles keeps mem_wdata stable and no new bus_req issues. Asserting rst while in BUSY clears bus_req asynchronously, and the next edge after rst falls starts in IDLE.
